// File: rtl/data_sram_if.sv
// Data-SRAM request/response bus between a CPU-side initiator and the memory.
// Signals:
//   en      request valid (chip enable), initiator -> memory
//   we      1 = write, 0 = read, sampled with en
//   sel     byte-lane select, sel[i] covers bits [8*i+7:8*i]
//   addr    byte address
//   wdata   write data, already replicated into lanes by the initiator
//   addr_ok memory can accept a request this cycle
//   data_ok one-cycle response pulse
//   rdata   read data
//   err     out-of-range flag, meaningful only with data_ok
interface data_sram_if;
    logic        en;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output en, we, sel, addr, wdata,
        input  addr_ok, data_ok, rdata, err
    );

    modport slave (
        input  en, we, sel, addr, wdata,
        output addr_ok, data_ok, rdata, err
    );
endinterface

// File: rtl/data_sram_resp.sv
// Memory-side responder for the CPU data-SRAM port. Accepts one request at a
// time, answers with a single data_ok pulse LATENCY cycles after acceptance,
// performs byte-lane-masked writes and full-word reads, and flags addresses
// beyond the array capacity with err.
// Parameters:
//   ADDR_W   word-index width, capacity 2**ADDR_W 32-bit words
//   LATENCY  cycles from accept to data_ok, 1..15
// Ports:
//   clk      rising-edge clock
//   resetn   asynchronous active-low reset (memory array is not cleared)
//   bus      data_sram_if slave side (en/we/sel/addr/wdata in,
//            addr_ok/data_ok/rdata/err out)
module data_sram_resp #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        resetn,
    data_sram_if.slave  bus
);

    localparam int DEPTH = 1 << ADDR_W;

    generate
        if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
            $error("data_sram_resp: LATENCY must be in 1..15");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;

    logic        we_p0;
    logic [3:0]  sel_p0;
    logic [31:0] addr_p0;
    logic [31:0] wdata_p0;

    logic [31:0] mem [0:DEPTH-1];
    logic [31:0] rdata_q;

    logic        accept;
    logic [31:0] rd_addr;
    logic        rd_we;
    logic        rd_oor;
    logic        req_oor;
    logic        load_rdata;
    logic        unused_addr_lsb;

    function automatic logic [31:0] lane_merge(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  lanes);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) begin
            m[i*8 +: 8] = lanes[i] ? new_w[i*8 +: 8] : old_w[i*8 +: 8];
        end
        return m;
    endfunction

    assign accept = (state == IDLE) && bus.en;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (bus.en) begin
                    cnt_nxt   = 4'(LATENCY - 1);
                    state_nxt = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // ---- stage p0: request captured at accept, inputs ignored afterwards ----
    always_ff @(posedge clk) begin
        if (accept) begin
            we_p0    <= bus.we;
            sel_p0   <= bus.sel;
            addr_p0  <= bus.addr;
            wdata_p0 <= bus.wdata;
        end
    end

    // For LATENCY==1 the RESP state is entered on the accept edge itself, so
    // the read must be taken from the live bus rather than the capture regs.
    assign rd_addr    = (state == IDLE) ? bus.addr : addr_p0;
    assign rd_we      = (state == IDLE) ? bus.we   : we_p0;
    assign rd_oor     = |rd_addr[31:ADDR_W+2];
    assign load_rdata = (state != RESP) && (state_nxt == RESP) && !rd_we;

    // ---- response stage: rdata registered into the RESP cycle ----
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdata_q <= 32'd0;
        end else if (load_rdata) begin
            rdata_q <= rd_oor ? 32'd0 : mem[rd_addr[ADDR_W+1:2]];
        end
    end

    // Write commits on the edge that closes RESP; an asynchronous reset before
    // that edge has already forced state back to IDLE, so nothing is written.
    assign req_oor = |addr_p0[31:ADDR_W+2];

    always_ff @(posedge clk) begin
        if (state == RESP && we_p0 && !req_oor) begin
            mem[addr_p0[ADDR_W+1:2]] <= lane_merge(mem[addr_p0[ADDR_W+1:2]],
                                                   wdata_p0, sel_p0);
        end
    end

    assign unused_addr_lsb = ^{addr_p0[1:0], rd_addr[1:0]};

    assign bus.addr_ok = resetn && (state == IDLE);
    assign bus.data_ok = (state == RESP);
    assign bus.err     = (state == RESP) && req_oor;
    assign bus.rdata   = rdata_q;

endmodule

// File: tb/tb_data_sram_resp.sv
// Directed bench for data_sram_resp. Three instances cover LATENCY=1, 4 and 3,
// each with its own bus and reset so they can be exercised independently.
module tb_data_sram_resp;

    logic clk;
    int   checks;
    int   failures;

    logic        en_v    [3];
    logic        we_v    [3];
    logic [3:0]  sel_v   [3];
    logic [31:0] addr_v  [3];
    logic [31:0] wdata_v [3];
    logic        resetn_v[3];

    logic [2:0]  aok;
    logic [2:0]  dok;
    logic [2:0]  er;
    logic [31:0] rd [3];

    data_sram_if b0 ();
    data_sram_if b1 ();
    data_sram_if b2 ();

    assign b0.en = en_v[0]; assign b0.we = we_v[0]; assign b0.sel = sel_v[0];
    assign b0.addr = addr_v[0]; assign b0.wdata = wdata_v[0];
    assign b1.en = en_v[1]; assign b1.we = we_v[1]; assign b1.sel = sel_v[1];
    assign b1.addr = addr_v[1]; assign b1.wdata = wdata_v[1];
    assign b2.en = en_v[2]; assign b2.we = we_v[2]; assign b2.sel = sel_v[2];
    assign b2.addr = addr_v[2]; assign b2.wdata = wdata_v[2];

    assign aok[0] = b0.addr_ok; assign dok[0] = b0.data_ok; assign er[0] = b0.err; assign rd[0] = b0.rdata;
    assign aok[1] = b1.addr_ok; assign dok[1] = b1.data_ok; assign er[1] = b1.err; assign rd[1] = b1.rdata;
    assign aok[2] = b2.addr_ok; assign dok[2] = b2.data_ok; assign er[2] = b2.err; assign rd[2] = b2.rdata;

    data_sram_resp #(.ADDR_W(10), .LATENCY(1)) u_lat1 (.clk(clk), .resetn(resetn_v[0]), .bus(b0));
    data_sram_resp #(.ADDR_W(10), .LATENCY(4)) u_lat4 (.clk(clk), .resetn(resetn_v[1]), .bus(b1));
    data_sram_resp #(.ADDR_W(10), .LATENCY(3)) u_lat3 (.clk(clk), .resetn(resetn_v[2]), .bus(b2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One complete request on instance k. Inputs are scrambled right after the
    // accept edge; lat is the number of edges from accept to data_ok (-1 if none).
    task automatic do_req(input int k, input logic w, input logic [3:0] s,
                          input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] r, output logic e, output int lat);
        lat = -1;
        r   = 32'hxxxx_xxxx;
        e   = 1'bx;
        @(negedge clk);
        en_v[k] = 1'b1; we_v[k] = w; sel_v[k] = s; addr_v[k] = a; wdata_v[k] = d;
        for (int n = 0; n < 40 && !aok[k]; n++) @(negedge clk);
        @(posedge clk);
        #1;
        en_v[k] = 1'b0; we_v[k] = ~w; sel_v[k] = ~s; addr_v[k] = 32'hFFFF_FFFC; wdata_v[k] = ~d;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (dok[k]) begin
                lat = n;
                r   = rd[k];
                e   = er[k];
                break;
            end
        end
        @(negedge clk);
        check("pulse_end", {30'd0, dok[k], er[k]}, 32'd0);
    endtask

    logic [31:0] r;
    logic        e;
    int          lat;
    logic [10:0] ao_bits;
    logic [10:0] do_bits;
    logic [31:0] rd4, rd9;
    logic        seen;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0;
        failures = 0;
        for (int k = 0; k < 3; k++) begin
            en_v[k] = 1'b0; we_v[k] = 1'b0; sel_v[k] = 4'h0;
            addr_v[k] = 32'd0; wdata_v[k] = 32'd0; resetn_v[k] = 1'b0;
        end
        repeat (3) @(negedge clk);
        check("rst_addr_ok", {31'd0, aok[0]}, 32'd0);
        check("rst_data_ok", {29'd0, dok}, 32'd0);
        check("rst_rdata",   rd[0], 32'd0);
        check("rst_err",     {29'd0, er}, 32'd0);
        for (int k = 0; k < 3; k++) resetn_v[k] = 1'b1;
        #1;
        check("rel_addr_ok", {29'd0, aok}, 32'd7);

        // basic write/read at LATENCY=1
        do_req(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, r, e, lat);
        check("t1_wr_lat", lat, 1);
        check("t1_wr_err", {31'd0, e}, 32'd0);
        do_req(0, 1'b0, 4'hF, 32'h10, 32'd0, r, e, lat);
        check("t1_rd_lat", lat, 1);
        check("t1_rd_data", r, 32'hDEADBEEF);
        check("t1_rd_err", {31'd0, e}, 32'd0);

        // byte-lane merge
        do_req(0, 1'b1, 4'hF, 32'h20, 32'h11223344, r, e, lat);
        do_req(0, 1'b1, 4'b0100, 32'h20, 32'hAAAAAAAA, r, e, lat);
        do_req(0, 1'b1, 4'b0001, 32'h20, 32'h55555555, r, e, lat);
        do_req(0, 1'b0, 4'h0, 32'h20, 32'd0, r, e, lat);
        check("t2_merge", r, 32'h11AA3355);

        // out of range and aliasing
        do_req(0, 1'b0, 4'hF, 32'h0000_1000, 32'd0, r, e, lat);
        check("t4_oor_rd_err", {31'd0, e}, 32'd1);
        check("t4_oor_rd_data", r, 32'd0);
        do_req(0, 1'b1, 4'hF, 32'h0, 32'h0BADC0DE, r, e, lat);
        do_req(0, 1'b0, 4'h0, 32'h13, 32'd0, r, e, lat);
        check("t4_lsb_ignored", r, 32'hDEADBEEF);
        do_req(0, 1'b1, 4'hF, 32'h0000_1000, 32'hFFFFFFFF, r, e, lat);
        check("t4_oor_wr_err", {31'd0, e}, 32'd1);
        check("t4_oor_wr_rdata", r, 32'hDEADBEEF);
        do_req(0, 1'b0, 4'hF, 32'h0, 32'd0, r, e, lat);
        check("t4_alias", r, 32'h0BADC0DE);
        check("t4_alias_err", {31'd0, e}, 32'd0);

        // empty lane mask
        do_req(0, 1'b1, 4'hF, 32'h30, 32'hCAFEF00D, r, e, lat);
        do_req(0, 1'b1, 4'h0, 32'h30, 32'h12345678, r, e, lat);
        check("t5_sel0_lat", lat, 1);
        check("t5_sel0_err", {31'd0, e}, 32'd0);
        do_req(0, 1'b0, 4'hF, 32'h30, 32'd0, r, e, lat);
        check("t5_sel0_data", r, 32'hCAFEF00D);

        // LATENCY=4 back-to-back with en held
        do_req(1, 1'b1, 4'hF, 32'h8, 32'hA5A5_0F0F, r, e, lat);
        check("t3_wr_lat", lat, 4);
        @(negedge clk);
        en_v[1] = 1'b1; we_v[1] = 1'b0; sel_v[1] = 4'hF; addr_v[1] = 32'h8;
        ao_bits = '0; do_bits = '0; rd4 = '0; rd9 = '0;
        for (int i = 0; i <= 10; i++) begin
            if (i > 0) @(negedge clk);
            ao_bits[i] = aok[1];
            do_bits[i] = dok[1];
            if (i == 4) rd4 = rd[1];
            if (i == 9) begin
                rd9 = rd[1];
                en_v[1] = 1'b0;
            end
        end
        check("t3_addr_ok_seq", {21'd0, ao_bits}, 32'h421);
        check("t3_data_ok_seq", {21'd0, do_bits}, 32'h210);
        check("t3_rd1", rd4, 32'hA5A5_0F0F);
        check("t3_rd2", rd9, 32'hA5A5_0F0F);

        // LATENCY=3 reset during WAIT
        do_req(2, 1'b1, 4'hF, 32'h40, 32'h0F0F0F0F, r, e, lat);
        check("t6_wr_lat", lat, 3);
        @(negedge clk);
        en_v[2] = 1'b1; we_v[2] = 1'b1; sel_v[2] = 4'hF; addr_v[2] = 32'h40; wdata_v[2] = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        en_v[2] = 1'b0;
        check("t6_in_wait", {31'd0, aok[2]}, 32'd0);
        resetn_v[2] = 1'b0;
        #1;
        check("t6_rst_outs", {30'd0, aok[2], dok[2]}, 32'd0);
        repeat (2) @(negedge clk);
        resetn_v[2] = 1'b1;
        #1;
        check("t6_rel_addr_ok", {31'd0, aok[2]}, 32'd1);
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen = seen | dok[2];
        end
        check("t6_no_data_ok", {31'd0, seen}, 32'd0);
        check("t6_rdata_rst", rd[2], 32'd0);
        do_req(2, 1'b0, 4'hF, 32'h40, 32'd0, r, e, lat);
        check("t6_rd_lat", lat, 3);
        check("t6_prior_value", r, 32'h0F0F0F0F);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
